his_peak_finder: RTL and testbench
==================================

// Module: his_peak_finder
// PURPOSE
//  Downstream of the histogram builder. When a histogram bank completes, scans it once.
//  Reads all bins over the RAM read port and tracks the 3-bin sliding-window sum.
//  Reports the centre bin of the largest window and its sum, plus the minimum single-bin
//  count as the ambient floor. The result goes to the depth/data-formatting stage through
//  a valid/ready handshake.
// PARAMETERS
//  NB       8              bin address width
//  BIN_NUM  256            bins per histogram, >=3, <=2**NB
//  CNT_W    16             bin count width
//  SUM_W    CNT_W+2        window-sum width (localparam, never overflows)
// PORTS
//  clk         in   1      clock, rising edge
//  res         in   1      asynchronous reset, active-high
//  start       in   1      1-cycle pulse: bank his_sel is complete
//  his_sel     in   1      bank to scan (builder's hisNum before its toggle)
//  rd_en       out  1      histogram RAM read enable
//  rd_sel      out  1      bank select for the read, = latched his_sel
//  rd_addr     out  NB     bin address
//  rd_data     in   CNT_W  bin count, valid the cycle after rd_en
//  peak_valid  out  1      result valid, held until accepted
//  peak_ready  in   1      consumer accepts the result
//  peak_bin    out  NB     centre bin of the max window
//  peak_sum    out  SUM_W  max window sum
//  ambient     out  CNT_W  minimum single-bin count
//  peak_found  out  1      peak_sum != 0
//  busy        out  1      state != IDLE
//  start_drop  out  1      1-cycle pulse: start ignored while busy
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, internal window/max/min cleared.
//  All outputs are registered. Reset mid-scan aborts immediately and no result is produced.
//  FSM states: IDLE -> READ -> DRAIN -> HOLD -> IDLE.
//  IDLE: on start, latch his_sel, clear max, set min to all-ones, clear window, go to READ.
//   Cycle after start: rd_en=1, rd_addr=0.
//  READ: rd_en=1. rd_addr increments 0..BIN_NUM-1, one per cycle.
//   After addr BIN_NUM-1 is issued, go to DRAIN; rd_en=0 in DRAIN.
//  Data path: rd_data is captured the cycle after each rd_en. Shift window w2<=w1, w1<=w0, w0<=rd_data.
//   min <= min(min, rd_data) for every bin.
//   Once bin k>=2 is in w0: s = w0+w1+w2, centre = k-1.
//   If s > max (strictly), update max and centre. Ties keep the earliest centre.
//   Centres range only over 1..BIN_NUM-2. Edge bins count only inside windows.
//  DRAIN: the last bin is processed, then go to HOLD.
//   On HOLD entry: peak_bin/peak_sum/ambient/peak_found are loaded and peak_valid=1.
//   Latency: start in cycle 0 -> peak_valid first high in cycle BIN_NUM+2.
//  HOLD: outputs stable while peak_valid && !peak_ready.
//   When peak_valid && peak_ready: next cycle peak_valid=0, go to IDLE. Data outputs keep the last value.
//  No window sum > 0: peak_sum=0, peak_bin=0, peak_found=0; ambient still reported.
//  start while busy (READ/DRAIN/HOLD): ignored, start_drop=1 for one cycle.
//   The scan in progress is unaffected.
//  start in the same cycle as the HOLD->IDLE transition: ignored and flagged as busy.
//  rd_addr wraps only by returning to 0 at the next scan. No address beyond BIN_NUM-1 is issued.
// TESTING
//  T1 peak: bins 99/100/101 = 50/80/60, others 2, BIN_NUM=256.
//   -> peak_bin=100, peak_sum=190, ambient=2, peak_found=1, peak_valid at cycle 258.
//  T2 tie: windows centred at 40 and 200 both sum 90, others 0.
//   -> peak_bin=40, peak_sum=90, ambient=0.
//  T3 zero histogram: all bins 0.
//   -> peak_found=0, peak_bin=0, peak_sum=0, ambient=0.
//  T4 edge: bin0=100, all others 1.
//   -> peak_bin=1, peak_sum=102, ambient=1.
//  T5 backpressure: peak_ready low 20 cycles, with start pulses during READ and HOLD.
//   -> outputs stable; start_drop pulses once per start; single result accepted; then IDLE, busy=0.
//  T6 reset mid-READ at rd_addr=77.
//   -> rd_en=0, busy=0, peak_valid=0 immediately.
//   A new start then scans from addr 0 and gives the correct T1 result.

Source files
------------

// File: rtl/his_peak_finder.sv
// Scans one completed histogram bank, finds the 3-bin window with the largest sum and the
// minimum single-bin count, and hands the result downstream over a valid/ready handshake.
module his_peak_finder #(
  parameter int unsigned NB      = 8,
  parameter int unsigned BIN_NUM = 256,
  parameter int unsigned CNT_W   = 16,
  localparam int unsigned SUM_W  = CNT_W + 2
) (
  input  logic             clk,
  input  logic             res,
  input  logic             start,
  input  logic             his_sel,
  output logic             rd_en,
  output logic             rd_sel,
  output logic [NB-1:0]    rd_addr,
  input  logic [CNT_W-1:0] rd_data,
  output logic             peak_valid,
  input  logic             peak_ready,
  output logic [NB-1:0]    peak_bin,
  output logic [SUM_W-1:0] peak_sum,
  output logic [CNT_W-1:0] ambient,
  output logic             peak_found,
  output logic             busy,
  output logic             start_drop
);

  localparam logic [NB-1:0] LastAddr = NB'(BIN_NUM - 1);

  typedef enum logic [1:0] {StIdle, StRead, StDrain, StHold} state_e;

  state_e           state_q, state_d;
  logic             rd_en_d, rd_sel_d, valid_d, busy_d, drop_d;
  logic [NB-1:0]    addr_d;
  logic             clear, load;

  // Read data belongs to the address issued one cycle earlier.
  logic             dv_q;
  logic [NB-1:0]    idx_q;
  logic [CNT_W-1:0] win0_q, win1_q;
  logic [SUM_W-1:0] max_q, max_d, win_sum;
  logic [NB-1:0]    bin_q, bin_d;
  logic [CNT_W-1:0] min_q, min_d;

  always_comb begin
    state_d  = state_q;
    rd_en_d  = 1'b0;
    addr_d   = rd_addr;
    rd_sel_d = rd_sel;
    valid_d  = peak_valid;
    clear    = 1'b0;
    load     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d  = StRead;
          rd_en_d  = 1'b1;
          addr_d   = '0;
          rd_sel_d = his_sel;
          clear    = 1'b1;
        end
      end
      StRead: begin
        if (rd_addr == LastAddr) begin
          state_d = StDrain;
        end else begin
          rd_en_d = 1'b1;
          addr_d  = rd_addr + NB'(1);
        end
      end
      StDrain: begin
        state_d = StHold;
        valid_d = 1'b1;
        load    = 1'b1;
      end
      StHold: begin
        if (peak_ready) begin
          state_d = StIdle;
          valid_d = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
    busy_d = (state_d != StIdle);
    drop_d = start && (state_q != StIdle);
  end

  // The final bin arrives during DRAIN, so the result is taken from the next-state values.
  always_comb begin
    win_sum = SUM_W'(rd_data) + SUM_W'(win0_q) + SUM_W'(win1_q);
    max_d   = max_q;
    bin_d   = bin_q;
    min_d   = min_q;
    if (dv_q) begin
      if (rd_data < min_q) min_d = rd_data;
      if (idx_q >= NB'(2) && win_sum > max_q) begin
        max_d = win_sum;
        bin_d = idx_q - NB'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state_q    <= StIdle;
      rd_en      <= 1'b0;
      rd_sel     <= 1'b0;
      rd_addr    <= '0;
      peak_valid <= 1'b0;
      busy       <= 1'b0;
      start_drop <= 1'b0;
    end else begin
      state_q    <= state_d;
      rd_en      <= rd_en_d;
      rd_sel     <= rd_sel_d;
      rd_addr    <= addr_d;
      peak_valid <= valid_d;
      busy       <= busy_d;
      start_drop <= drop_d;
    end
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      dv_q   <= 1'b0;
      idx_q  <= '0;
      win0_q <= '0;
      win1_q <= '0;
      max_q  <= '0;
      bin_q  <= '0;
      min_q  <= '0;
    end else begin
      dv_q  <= rd_en;
      idx_q <= rd_addr;
      if (clear) begin
        win0_q <= '0;
        win1_q <= '0;
        max_q  <= '0;
        bin_q  <= '0;
        min_q  <= '1;
      end else if (dv_q) begin
        win0_q <= rd_data;
        win1_q <= win0_q;
        max_q  <= max_d;
        bin_q  <= bin_d;
        min_q  <= min_d;
      end
    end
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      peak_bin   <= '0;
      peak_sum   <= '0;
      ambient    <= '0;
      peak_found <= 1'b0;
    end else if (load) begin
      peak_bin   <= bin_d;
      peak_sum   <= max_d;
      ambient    <= min_d;
      peak_found <= (max_d != '0);
    end
  end

endmodule

// File: tb/tb_his_peak_finder.sv
// Directed bench for his_peak_finder: a two-bank RAM model with one-cycle read latency.
module tb_his_peak_finder;

  localparam int NB = 8;
  localparam int BIN_NUM = 256;
  localparam int CNT_W = 16;
  localparam int SUM_W = CNT_W + 2;

  logic             clk = 1'b0;
  logic             res = 1'b1;
  logic             start = 1'b0;
  logic             his_sel = 1'b0;
  logic             rd_en, rd_sel;
  logic [NB-1:0]    rd_addr;
  logic [CNT_W-1:0] rd_data = '0;
  logic             peak_valid;
  logic             peak_ready = 1'b0;
  logic [NB-1:0]    peak_bin;
  logic [SUM_W-1:0] peak_sum;
  logic [CNT_W-1:0] ambient;
  logic             peak_found, busy, start_drop;

  logic [CNT_W-1:0] mem [2][BIN_NUM];
  int               rd_cnt = 0;
  int               addr_err = 0;
  logic             prev_en = 1'b0;
  logic [NB-1:0]    prev_addr = '0;

  int n_pass = 0;
  int n_total = 0;

  his_peak_finder #(.NB(NB), .BIN_NUM(BIN_NUM), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .res        (res),
    .start      (start),
    .his_sel    (his_sel),
    .rd_en      (rd_en),
    .rd_sel     (rd_sel),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .peak_valid (peak_valid),
    .peak_ready (peak_ready),
    .peak_bin   (peak_bin),
    .peak_sum   (peak_sum),
    .ambient    (ambient),
    .peak_found (peak_found),
    .busy       (busy),
    .start_drop (start_drop)
  );

  always #5 clk = ~clk;

  // RAM model plus a monitor that every scan issues 0,1,2,... without gaps.
  always @(posedge clk) begin
    if (rd_en) begin
      rd_data <= mem[rd_sel][rd_addr];
      rd_cnt  <= rd_cnt + 1;
      if (!prev_en ? (rd_addr != '0) : (rd_addr != prev_addr + NB'(1))) addr_err <= addr_err + 1;
    end
    prev_en   <= rd_en;
    prev_addr <= rd_addr;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // pat: 1 = peak, 2 = tie, 3 = zero, 4 = edge; the other bank holds a decoy.
  task automatic fill(input logic sel, input int pat);
    for (int i = 0; i < BIN_NUM; i++) begin
      mem[~sel][i] = 16'd500;
      case (pat)
        1: mem[sel][i] = (i == 99) ? 16'd50 : (i == 100) ? 16'd80 : (i == 101) ? 16'd60 : 16'd2;
        2: mem[sel][i] = ((i >= 39 && i <= 41) || (i >= 199 && i <= 201)) ? 16'd30 : 16'd0;
        3: mem[sel][i] = 16'd0;
        default: mem[sel][i] = (i == 0) ? 16'd100 : 16'd1;
      endcase
    end
  endtask

  task automatic pulse_start(input logic sel);
    @(negedge clk);
    his_sel = sel;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_valid(output int cyc);
    cyc = 0;
    while (!peak_valid && cyc < 1000) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic accept(input string tag);
    @(negedge clk);
    peak_ready = 1'b1;
    @(negedge clk);
    peak_ready = 1'b0;
    check({tag, "_valid_after_accept"}, peak_valid, 1'b0);
    check({tag, "_busy_after_accept"}, busy, 1'b0);
  endtask

  task automatic full_scan(input string tag, input logic sel, input int eb, input int es,
                           input int ea, input int ef);
    int lat;
    int cnt0;
    logic first_ok;
    cnt0 = rd_cnt;
    @(negedge clk);
    his_sel = sel;
    start = 1'b1;
    lat = 0;
    first_ok = 1'b0;
    do begin
      @(negedge clk);
      start = 1'b0;
      lat++;
      if (lat == 1) first_ok = rd_en && (rd_addr == '0) && (rd_sel == sel) && busy;
    end while (!peak_valid && lat < 1000);
    check({tag, "_first_read"}, first_ok, 1'b1);
    check({tag, "_latency"}, lat, BIN_NUM + 2);
    check({tag, "_reads"}, rd_cnt - cnt0, BIN_NUM);
    check({tag, "_bin"}, peak_bin, eb);
    check({tag, "_sum"}, peak_sum, es);
    check({tag, "_ambient"}, ambient, ea);
    check({tag, "_found"}, peak_found, ef);
    accept(tag);
  endtask

  initial begin
    int   cyc;
    int   changes;
    int   drops;
    logic stray;
    logic [NB-1:0]    h_bin;
    logic [SUM_W-1:0] h_sum;
    logic [CNT_W-1:0] h_amb;

    repeat (3) @(negedge clk);
    check("rst_rd_en", rd_en, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_valid", peak_valid, 1'b0);
    check("rst_outputs", {peak_bin, peak_sum, ambient, peak_found, start_drop}, '0);
    res = 1'b0;

    fill(1'b1, 1);
    full_scan("t1", 1'b1, 100, 190, 2, 1);
    repeat (3) @(negedge clk);
    check("t1_bin_kept", peak_bin, 100);

    fill(1'b0, 2);
    full_scan("t2", 1'b0, 40, 90, 0, 1);
    fill(1'b0, 3);
    full_scan("t3", 1'b0, 0, 0, 0, 0);
    fill(1'b1, 4);
    full_scan("t4", 1'b1, 1, 102, 1, 1);

    // T5: backpressure with dropped starts during READ and HOLD
    fill(1'b0, 1);
    pulse_start(1'b0);
    repeat (50) @(negedge clk);
    drops = 0;
    @(negedge clk);
    start = 1'b1;
    his_sel = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("t5_drop_read", start_drop, 1'b1);
    @(negedge clk);
    check("t5_drop_one_cycle", start_drop, 1'b0);
    wait_valid(cyc);
    check("t5_valid_seen", peak_valid, 1'b1);
    h_bin = peak_bin;
    h_sum = peak_sum;
    h_amb = ambient;
    changes = 0;
    for (int i = 0; i < 20; i++) begin
      start = (i == 5);
      @(negedge clk);
      if (start_drop) drops++;
      if (!peak_valid || peak_bin != h_bin || peak_sum != h_sum || ambient != h_amb) changes++;
    end
    start = 1'b0;
    check("t5_stable", changes, 0);
    check("t5_drop_hold", drops, 1);
    check("t5_sum", h_sum, 190);
    check("t5_rd_sel", rd_sel, 1'b0);
    start = 1'b1;
    peak_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    peak_ready = 1'b0;
    check("t5_valid_low", peak_valid, 1'b0);
    check("t5_idle", busy, 1'b0);
    check("t5_drop_accept", start_drop, 1'b1);
    stray = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (rd_en || busy || peak_valid) stray = 1'b1;
    end
    check("t5_no_restart", stray, 1'b0);

    // T6: reset mid-scan, then a clean rescan
    fill(1'b0, 4);
    pulse_start(1'b0);
    cyc = 0;
    while (rd_addr != NB'(77) && cyc < 400) begin
      @(negedge clk);
      cyc++;
    end
    check("t6_reached_77", rd_addr, 77);
    res = 1'b1;
    #1;
    check("t6_rd_en", rd_en, 1'b0);
    check("t6_busy", busy, 1'b0);
    check("t6_valid", peak_valid, 1'b0);
    @(negedge clk);
    res = 1'b0;
    fill(1'b0, 1);
    full_scan("t6", 1'b0, 100, 190, 2, 1);

    check("addr_sequence", addr_err, 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
